lock_code_sender: RTL and testbench



---
 rtl/lock_code_sender.sv | 122 ++++++++++++
 tb/tb_lock_code_sender.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lock_code_sender.sv
// lock_code_sender: bit-serial transmitter for the 6-bit sequence lock.
// Latches a parallel code on start, drives a guard gap and then the code
// MSB-first. It samples the lock's unlock flag with the last bit and retries
// up to MAX_TRIES attempts. It reports back through start/busy/done/ok/tries.
module lock_code_sender #(
  parameter int WIDTH      = 6,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_TRIES  = 3,
  parameter int TRY_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] code,
  input  logic             l_in,
  output logic             a_out,
  output logic             busy,
  output logic             done,
  output logic             ok,
  output logic [TRY_W-1:0] tries
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, GAP, SEND, FIN} state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   code_q, code_d;
  logic [GAP_W-1:0]   gap_cnt, gap_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [TRY_W-1:0]   tries_d;
  logic               ok_d, a_out_d, busy_d, done_d;

  // Next-state, counters and the values the output registers take next.
  always_comb begin
    // NOTE: every comb-assigned signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state;
    code_d  = code_q;
    gap_d   = gap_cnt;
    idx_d   = idx;
    tries_d = tries;
    ok_d    = ok;

    unique case (state)
      IDLE: begin
        if (start) begin
          code_d  = code;
          tries_d = '0;
          ok_d    = 1'b0;
          gap_d   = GAP_W'(GAP_CYCLES - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          idx_d   = IDX_W'(WIDTH - 1);
          state_d = SEND;
        end else begin
          gap_d = gap_cnt - 1'b1;
        end
      end
      SEND: begin
        if (idx == '0) begin
          // Last bit: the unlock flag is only meaningful on this edge.
          tries_d = tries + 1'b1;
          if (l_in) begin
            ok_d    = 1'b1;
            state_d = FIN;
          end else if (tries + 1'b1 == TRY_W'(MAX_TRIES)) begin
            ok_d    = 1'b0;
            state_d = FIN;
          end else begin
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = GAP;
          end
        end else begin
          idx_d = idx - 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so derive them from where the FSM is heading.
    a_out_d = 1'b0;
    unique case (state_d)
      GAP:     a_out_d = ~code_d[WIDTH-1];
      SEND:    a_out_d = code_d[idx_d];
      default: a_out_d = 1'b0;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      code_q  <= '0;
      gap_cnt <= '0;
      idx     <= '0;
      tries   <= '0;
      ok      <= 1'b0;
      a_out   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state   <= state_d;
      code_q  <= code_d;
      gap_cnt <= gap_d;
      idx     <= idx_d;
      tries   <= tries_d;
      ok      <= ok_d;
      a_out   <= a_out_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_lock_code_sender.sv
// Self-checking bench for lock_code_sender. Requests are logged in a
// scoreboard queue (expected ok, tries, start-to-done latency). A monitor pops
// and compares an entry on every done pulse. The lock is modelled as a 6-bit
// shift-register comparator, or l_in is forced directly by the stimulus.
module tb_lock_code_sender;

  localparam int WIDTH = 6;
  localparam int TRY_W = 2;
  localparam logic [WIDTH-1:0] PWD = 6'b111000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] code;
  logic             l_in;
  logic             a_out, busy, done, ok;
  logic [TRY_W-1:0] tries;

  // Lock stub: l_mode=1 -> sequence lock on a_out; l_mode=0 -> lin_force.
  logic             l_mode;
  logic             lin_force;
  logic [WIDTH-1:0] hist = '0;

  typedef struct {
    logic             ok;
    logic [TRY_W-1:0] tries;
    int               lat;
    int               e0;
  } exp_t;

  exp_t sb[$];
  int   edges    = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  lock_code_sender #(.WIDTH(WIDTH), .GAP_CYCLES(2), .MAX_TRIES(3), .TRY_W(TRY_W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .code  (code),
    .l_in  (l_in),
    .a_out (a_out),
    .busy  (busy),
    .done  (done),
    .ok    (ok),
    .tries (tries)
  );

  always #5 clk = ~clk;

  always @(posedge clk) hist <= {hist[WIDTH-2:0], a_out};
  assign l_in = l_mode ? ({hist[WIDTH-2:0], a_out} == PWD) : lin_force;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: sample #1 after each rising edge.
  always @(posedge clk) begin
    edges++;
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", done, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ok", ok, e.ok);
        check("tries", tries, e.tries);
        check("latency", edges - e.e0, e.lat);
        check("busy_at_done", busy, 1'b1);
        check("a_out_at_done", a_out, 1'b0);
      end
    end
  end

  // Drive a one-cycle start pulse (from a negedge) and log the expectation.
  // Returns at the negedge following the accepting edge E0.
  task automatic send_req(input logic [WIDTH-1:0] c, input logic e_ok,
                          input logic [TRY_W-1:0] e_tries, input int e_lat);
    exp_t e;
    code  = c;
    start = 1'b1;
    e.ok = e_ok; e.tries = e_tries; e.lat = e_lat; e.e0 = edges + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      check("timeout_pending", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq1;
    reset = 1'b1; start = 1'b0; code = '0; l_mode = 1'b1; lin_force = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a_out", a_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ok", ok, 1'b0);
    check("rst_tries", tries, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: matching code, lock opens on first try.
    seq1 = 8'b00111000;
    send_req(6'b111000, 1'b1, 2'd1, 8);
    check("t1_busy", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_a_out[%0d]", i), a_out, seq1[7-i]);
      @(negedge clk);
    end
    wait_idle(40);

    // 2: wrong code, all three attempts fail.
    send_req(6'b110000, 1'b0, 2'd3, 24);
    wait_idle(60);
    check("t2_a_out_after", a_out, 1'b0);
    check("t2_busy_after", busy, 1'b0);
    check("t2_ok_held", ok, 1'b0);

    // 3: forced l_in, success on second attempt.
    l_mode = 1'b0;
    send_req(6'b101101, 1'b1, 2'd2, 16);
    repeat (15) @(negedge clk);
    lin_force = 1'b1;
    @(negedge clk);
    lin_force = 1'b0;
    wait_idle(40);
    check("t3_ok_held", ok, 1'b1);

    // 4: start held high; second request accepted at E10 with a new code.
    l_mode = 1'b1;
    begin
      exp_t e;
      code  = 6'b111000;
      start = 1'b1;
      e.ok = 1'b1; e.tries = 2'd1; e.lat = 8; e.e0 = edges + 1;
      sb.push_back(e);
      e.ok = 1'b0; e.tries = 2'd3; e.lat = 24; e.e0 = e.e0 + 10;
      sb.push_back(e);
    end
    @(negedge clk);
    code = 6'b010110;
    repeat (9) @(negedge clk);
    check("t4_busy_idle_gap", busy, 1'b0);
    @(negedge clk);
    check("t4_busy_reaccept", busy, 1'b1);
    check("t4_gap_bit_new_code", a_out, 1'b1);
    check("t4_tries_cleared", tries, 0);
    start = 1'b0;
    wait_idle(60);

    // 5: asynchronous reset during SEND idx=3.
    send_req(6'b111000, 1'b1, 2'd1, 8);
    void'(sb.pop_back());
    repeat (4) @(negedge clk);
    check("t5_a_out_before_rst", a_out, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_a_out", a_out, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_tries", tries, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_idle_after_rst", busy, 1'b0);
    send_req(6'b111000, 1'b1, 2'd1, 8);
    check("t5_restart_tries", tries, 0);
    wait_idle(40);

    // 6: spurious l_in in GAP and at SEND idx=3 is ignored; all tries fail.
    l_mode = 1'b0;
    send_req(6'b100110, 1'b0, 2'd3, 24);
    lin_force = 1'b1;
    @(negedge clk);
    lin_force = 1'b0;
    repeat (3) @(negedge clk);
    lin_force = 1'b1;
    @(negedge clk);
    lin_force = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_retry_busy", busy, 1'b1);
    wait_idle(60);
    check("t6_ok", ok, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
